// File: rtl/mau_pkg.sv
// ----------------------------------------------------------------------------
// mau_pkg : shared size encodings, FSM state type and byte-count lookup
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_CAPT  = 3'd2,
    S_WR       = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  // Encoding 2'b11 is handled as a word access.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mau_load_extend.sv
// ----------------------------------------------------------------------------
// mau_load_extend : sign/zero extension of assembled little-endian load data
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mau_load_extend
  import mau_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (size)
      SZ_BYTE: data = {{24{is_signed & raw[7]}}, raw[7:0]};
      SZ_HALF: data = {{16{is_signed & raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit : splits 32-bit LSQ loads/stores into byte-wide memory
// accesses. Optional misaligned trap: MAU_MISALIGN_TRAP_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_re,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] base;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic [1:0]            size;
  logic                  sgn;
  logic                  we;
  logic [TAG_WIDTH-1:0]  tag;
  logic [1:0]            cnt;
  logic [2:0]            nbytes;
  logic                  accept;
  logic                  last_byte;
  logic                  misalign;
  logic [31:0]           ext_data;

  assign accept    = (state == S_IDLE) && req_valid;
  assign last_byte = ({1'b0, cnt} == (nbytes - 3'd1));

`ifdef MAU_MISALIGN_TRAP_EN
  logic err;
  assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Address bits above ADDR_WIDTH are intentionally discarded.
  if (ADDR_WIDTH < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = |req_addr[31:ADDR_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (misalign)    state_next = S_RESP;
          else if (req_we) state_next = S_WR;
          else             state_next = S_RD_ISSUE;
        end
      end
      S_WR:       if (last_byte) state_next = S_RESP;
      S_RD_ISSUE: state_next = S_RD_CAPT;
      S_RD_CAPT:  state_next = last_byte ? S_RESP : S_RD_ISSUE;
      S_RESP:     if (resp_ready) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base   <= '0;
      wdata  <= '0;
      rdata  <= '0;
      size   <= SZ_BYTE;
      sgn    <= 1'b0;
      we     <= 1'b0;
      tag    <= '0;
      cnt    <= '0;
      nbytes <= 3'd1;
`ifdef MAU_MISALIGN_TRAP_EN
      err    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        base   <= req_addr[ADDR_WIDTH-1:0];
        wdata  <= req_wdata;
        rdata  <= '0;
        size   <= req_size;
        sgn    <= req_signed;
        we     <= req_we;
        tag    <= req_tag;
        cnt    <= '0;
        nbytes <= size_nbytes(req_size);
`ifdef MAU_MISALIGN_TRAP_EN
        err    <= misalign;
`endif
      end
      if (state == S_WR) cnt <= cnt + 2'd1;
      if (state == S_RD_CAPT) begin
        rdata[{cnt, 3'b000} +: 8] <= mem_rdata;
        cnt <= cnt + 2'd1;
      end
    end
  end

  mau_load_extend u_ext (
    .raw       (rdata),
    .size      (size),
    .is_signed (sgn),
    .data      (ext_data)
  );

  // Memory-side outputs are forced to zero outside the access states.
  always_comb begin
    req_ready   = (state == S_IDLE);
    mem_wr      = (state == S_WR);
    mem_re      = (state == S_RD_ISSUE);
    mem_address = '0;
    mem_wdata   = '0;
    if (mem_wr || mem_re) mem_address = base + ADDR_WIDTH'(cnt);
    if (mem_wr)           mem_wdata   = wdata[{cnt, 3'b000} +: 8];
    resp_valid  = (state == S_RESP);
    resp_tag    = resp_valid ? tag : '0;
`ifdef MAU_MISALIGN_TRAP_EN
    resp_err    = resp_valid && err;
    resp_rdata  = (resp_valid && !we && !err) ? ext_data : 32'h0;
`else
    resp_err    = 1'b0;
    resp_rdata  = (resp_valid && !we) ? ext_data : 32'h0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit : table-driven scoreboard bench for mem_access_unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_tag;
  logic        resp_valid, resp_ready, resp_err;
  logic [3:0]  resp_tag;
  logic [31:0] resp_rdata;
  logic        mem_re, mem_wr;
  logic [19:0] mem_address;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  mem_access_unit #(.ADDR_WIDTH(20), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_re(mem_re), .mem_wr(mem_wr), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int re_count = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t wlog[$];

  bit [7:0] mem [0:(1<<20)-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Byte-wide memory with one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr) begin
      mem[mem_address] <= mem_wdata;
      wlog.push_back('{addr: mem_address, data: mem_wdata});
    end
    if (mem_re) re_count <= re_count + 1;
    mem_rdata <= mem[mem_address];
    if (mem_re && mem_wr) $display("FAIL re_wr_overlap: got 1 expected 0");
  end

  // Scoreboard consumer: compares on every response handshake.
  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_tag",   {28'h0, resp_tag}, {28'h0, e.tag});
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err",   {31'h0, resp_err}, {31'h0, e.err});
      end
    end
  end

  function automatic int nb_of(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  // Called at a negedge; returns at the negedge where the response is visible.
  task automatic run_req(input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] tag, input int lat,
                         input logic [31:0] exp_rd, input bit exp_err);
    int n, t_acc, w0, r0, nwr, nre;
    req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_tag = tag; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept", {31'h0, req_ready}, 32'd1);
    t_acc = cyc; w0 = wlog.size(); r0 = re_count;
    sb.push_back('{tag: tag, rdata: exp_rd, err: exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin @(negedge clk); n++; end
    chk("resp_timeout", {31'h0, resp_valid}, 32'd1);
    chk("latency", cyc - t_acc, lat);
    nwr = (we && !exp_err) ? nb_of(size) : 0;
    nre = (!we && !exp_err) ? nb_of(size) : 0;
    chk("wr_count", wlog.size() - w0, nwr);
    chk("re_count", re_count - r0, nre);
    for (int i = 0; i < nwr && (w0 + i) < wlog.size(); i++) begin
      chk("wr_addr", {12'h0, wlog[w0+i].addr}, {12'h0, addr[19:0] + 20'(i)});
      chk("wr_data", {24'h0, wlog[w0+i].data}, {24'h0, wdata[8*i +: 8]});
    end
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  tag;
    int          lat;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'h1, 5, 32'h0000_0000};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,         4'h2, 3, 32'hFFFF_FFDE};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,         4'h3, 3, 32'h0000_00DE};
    vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         4'h4, 9, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0,         4'h5, 5, 32'hFFFF_BEEF};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,         4'h6, 5, 32'h0000_DEAD};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0200, 32'hFFFF_FF5A, 4'h7, 2, 32'h0000_0000};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0200, 32'h0,         4'h8, 3, 32'h0000_005A};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_8001, 4'h9, 3, 32'h0000_0000};
    vecs[9]  = '{1'b0, 2'b10, 1'b1, 32'h0000_0200, 32'h0,         4'hA, 9, 32'h8001_005A};
    vecs[10] = '{1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0,         4'hB, 5, 32'hFFFF_8001};
    vecs[11] = '{1'b0, 2'b11, 1'b1, 32'h0000_0100, 32'h0,         4'hC, 9, 32'hDEAD_BEEF};
    vecs[12] = '{1'b0, 2'b01, 1'b1, 32'hABC0_0100, 32'h0,         4'hD, 5, 32'hFFFF_BEEF};

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_tag = 4'h0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("rst_req_ready",  {31'h0, req_ready},  32'd1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_mem_strobe", {30'h0, mem_re, mem_wr}, 32'd0);
    chk("rst_mem_addr",   {12'h0, mem_address}, 32'd0);
    chk("rst_resp_data",  resp_rdata | {28'h0, resp_tag} | {31'h0, resp_err}, 32'd0);

    for (int i = 0; i < 13; i++)
      run_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr,
              vecs[i].wdata, vecs[i].tag, vecs[i].lat, vecs[i].rdata, 1'b0);

`ifdef MAU_MISALIGN_TRAP_EN
    run_req(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 4'h3, 1, 32'h0, 1'b1);
    run_req(1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h5555_5555, 4'h4, 1, 32'h0, 1'b1);
    run_req(1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 4'h5, 3, 32'h0000_00BE, 1'b0);
`else
    run_req(1'b1, 2'b01, 1'b0, 32'h000F_FFFF, 32'h0000_1234, 4'h3, 3, 32'h0, 1'b0);
    run_req(1'b0, 2'b10, 1'b0, 32'h000F_FFFF, 32'h0, 4'h4, 9, 32'h0000_1234, 1'b0);
    run_req(1'b0, 2'b01, 1'b1, 32'h0000_0101, 32'h0, 4'h5, 5, 32'hFFFF_ADBE, 1'b0);
`endif

    // Backpressure: response must hold while new requests are ignored.
    begin
      int n, w0;
      logic [31:0] hold_rd;
      logic [3:0]  hold_tag;
      @(negedge clk);
      resp_ready = 1'b0;
      req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h0000_0100; req_tag = 4'hE; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      sb.push_back('{tag: 4'hE, rdata: 32'hDEAD_BEEF, err: 1'b0});
      @(negedge clk);
      req_we = 1'b1; req_wdata = 32'h0; req_tag = 4'hF;
      n = 0;
      while (!resp_valid && n < 40) begin @(negedge clk); n++; end
      chk("bp_resp_timeout", {31'h0, resp_valid}, 32'd1);
      hold_rd = resp_rdata; hold_tag = resp_tag; w0 = wlog.size();
      chk("bp_rdata_first", hold_rd, 32'hDEAD_BEEF);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk("bp_valid",     {31'h0, resp_valid}, 32'd1);
        chk("bp_tag",       {28'h0, resp_tag},   {28'h0, hold_tag});
        chk("bp_rdata",     resp_rdata,          hold_rd);
        chk("bp_req_ready", {31'h0, req_ready},  32'd0);
      end
      chk("bp_no_writes", wlog.size() - w0, 32'd0);
      req_valid = 1'b0;
      @(posedge clk); #1 resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_back_idle", {31'h0, req_ready}, 32'd1);
    end

    // Reset during RD_CAPT of a word load: no response may follow.
    begin
      int n, t_acc, seen;
      req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0100;
      req_tag = 4'h6; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      t_acc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("abort_in_capt", {30'h0, mem_re, mem_wr}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_req_ready",  {31'h0, req_ready},  32'd1);
      chk("abort_resp_valid", {31'h0, resp_valid}, 32'd0);
      chk("abort_mem",        {10'h0, mem_re, mem_wr, mem_address}, 32'd0);
      chk("abort_resp_data",  resp_rdata | {28'h0, resp_tag}, 32'd0);
      rst = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      chk("abort_no_resp", seen, 32'd0);
      chk("abort_latency_ref", cyc - t_acc, 32'd15);
    end

    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
